// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master arbiter: FSM states, word width,
// default timeout and a small width helper.
package spi_pkg;

    localparam int SPI_DATA_W      = 16;
    localparam int SPI_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_DONE      = 3'd4
    } spi_state_e;

    // Bits needed to hold an index 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches the request vector starting
// one position after the previous winner and wraps around.
module rr_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N_REQ-1:0] o_win_onehot,
    output logic [IDX_W-1:0] o_win_idx,
    output logic             o_win_valid
);

    logic [IDX_W-1:0] w_cand_idx;

    // First pending request at or after last+1 (mod N_REQ) wins.
    always_comb begin
        o_win_onehot = '0;
        o_win_idx    = '0;
        o_win_valid  = 1'b0;
        w_cand_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand_idx = IDX_W'((int'(i_last) + k + 1) % N_REQ);
            if (!o_win_valid && i_req[w_cand_idx]) begin
                o_win_valid              = 1'b1;
                o_win_idx                = w_cand_idx;
                o_win_onehot[w_cand_idx] = 1'b1;
            end else begin
                o_win_valid = o_win_valid;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between N_REQ requesters. A round-robin winner is
// launched on the master, completion is detected from the cs low/high
// sequence, and a cycle counter aborts transfers whose cs never toggles.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = SPI_DATA_W,
    parameter int TIMEOUT_CYC = SPI_TIMEOUT_CYC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    timeout_err,
    output logic                    spi_start,
    output logic [DATA_W-1:0]       spi_tx_data,
    input  logic [DATA_W-1:0]       spi_rx_data,
    input  logic                    spi_cs
);

    localparam int               IDX_W    = idx_width(N_REQ);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    spi_state_e        r_state, w_state;
    logic [N_REQ-1:0]  r_gnt, w_gnt;
    logic [N_REQ-1:0]  r_done, w_done;
    logic [DATA_W-1:0] r_rsp, w_rsp;
    logic              r_to_err, w_to_err;
    logic              r_start, w_start;
    logic [DATA_W-1:0] r_tx, w_tx;
    logic [IDX_W-1:0]  r_last, w_last;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_tout, w_tout;

    logic [N_REQ-1:0]  w_win_onehot;
    logic [IDX_W-1:0]  w_win_idx;
    logic              w_win_valid;
    logic [DATA_W-1:0] w_slice [N_REQ];

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req        (req),
        .i_last       (r_last),
        .o_win_onehot (w_win_onehot),
        .o_win_idx    (w_win_idx),
        .o_win_valid  (w_win_valid)
    );

    // Split the flat request data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_slice[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Next-state and next-register values; pulses default low every cycle.
    always_comb begin
        w_state  = r_state;
        w_gnt    = r_gnt;
        w_done   = '0;
        w_rsp    = r_rsp;
        w_to_err = 1'b0;
        w_start  = 1'b0;
        w_tx     = r_tx;
        w_last   = r_last;
        w_cnt    = r_cnt;
        w_tout   = r_tout;
        case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_gnt   = w_win_onehot;
                    w_tx    = w_slice[w_win_idx];
                    w_last  = w_win_idx;
                    w_start = 1'b1;
                    w_tout  = 1'b0;
                    w_state = ST_START;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_START: begin
                w_cnt   = '0;
                w_state = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!spi_cs) begin
                    w_cnt   = r_cnt + CNT_ONE;
                    w_state = ST_WAIT_HIGH;
                end else if (r_cnt == CNT_LAST) begin
                    w_tout  = 1'b1;
                    w_state = ST_DONE;
                end else begin
                    w_cnt   = r_cnt + CNT_ONE;
                end
            end
            ST_WAIT_HIGH: begin
                if (spi_cs) begin
                    w_state = ST_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_tout  = 1'b1;
                    w_state = ST_DONE;
                end else begin
                    w_cnt   = r_cnt + CNT_ONE;
                end
            end
            ST_DONE: begin
                if (r_tout) begin
                    w_rsp = '0;
                end else begin
                    w_rsp = spi_rx_data;
                end
                w_done   = r_gnt;
                w_to_err = r_tout;
                w_gnt    = '0;
                w_state  = ST_IDLE;
            end
            default: begin
                w_gnt   = '0;
                w_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Datapath, grant, pulse and timeout-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt    <= '0;
            r_done   <= '0;
            r_rsp    <= '0;
            r_to_err <= 1'b0;
            r_start  <= 1'b0;
            r_tx     <= '0;
            r_last   <= LAST_RST;
            r_cnt    <= '0;
            r_tout   <= 1'b0;
        end else begin
            r_gnt    <= w_gnt;
            r_done   <= w_done;
            r_rsp    <= w_rsp;
            r_to_err <= w_to_err;
            r_start  <= w_start;
            r_tx     <= w_tx;
            r_last   <= w_last;
            r_cnt    <= w_cnt;
            r_tout   <= w_tout;
        end
    end

    assign gnt         = r_gnt;
    assign done        = r_done;
    assign rsp_data    = r_rsp;
    assign timeout_err = r_to_err;
    assign spi_start   = r_start;
    assign spi_tx_data = r_tx;

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: transaction-level reference model,
// a simple SPI master model, and directed scenarios with literal checks.
module tb_spi_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 64;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   rsp_data;
    logic           timeout_err;
    logic           spi_start;
    logic [W-1:0]   spi_tx_data;
    logic [W-1:0]   spi_rx_data;
    logic           spi_cs;

    spi_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .rsp_data    (rsp_data),
        .timeout_err (timeout_err),
        .spi_start   (spi_start),
        .spi_tx_data (spi_tx_data),
        .spi_rx_data (spi_rx_data),
        .spi_cs      (spi_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (oh[i]) r = i;
        return r;
    endfunction

    // Cycle counter for latency measurements.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- SPI master model ----------------
    // Drops cs 3 cycles after seeing start, holds it low 32 cycles, then
    // raises it and presents the receive word. In hang mode it never responds.
    logic         m_hang;
    logic [W-1:0] m_rx;
    int           mst;
    int           mcnt;

    initial begin
        spi_cs      = 1'b1;
        spi_rx_data = 16'h0000;
        mst         = 0;
        mcnt        = 0;
        forever begin
            @(negedge clk);
            if (mst == 0) begin
                if (spi_start && !m_hang) begin
                    mst  = 1;
                    mcnt = 3;
                end
            end else if (mst == 1) begin
                mcnt--;
                if (mcnt == 0) begin
                    spi_cs      = 1'b0;
                    spi_rx_data = 16'hFFFF;
                    mst         = 2;
                    mcnt        = 32;
                end
            end else begin
                mcnt--;
                if (mcnt == 0) begin
                    spi_cs      = 1'b1;
                    spi_rx_data = m_rx;
                    mst         = 0;
                end
            end
        end
    end

    // ---------------- Reference model ----------------
    // Tracks one transaction by elapsed cycles since its grant: the start
    // pulse occupies the first cycle, cs is watched from the third edge on,
    // the wait budget is TO cycles, and the result appears one edge after
    // completion is recognised.
    logic [N-1:0] e_gnt, e_done;
    logic [W-1:0] e_rsp, e_tx;
    logic         e_to, e_start;
    int m_busy, m_owner, m_last, m_t, m_fin, m_low, m_tout;

    task automatic m_clear();
        m_busy = 0; m_owner = 0; m_last = N - 1; m_t = 0;
        m_fin = 0; m_low = 0; m_tout = 0;
        e_gnt = '0; e_done = '0; e_rsp = '0; e_tx = '0; e_to = 1'b0; e_start = 1'b0;
    endtask

    task automatic m_step();
        int c;
        int waited;
        e_done = '0;
        e_to   = 1'b0;
        if (m_busy != 0) begin
            m_t++;
            if (m_fin != 0) begin
                e_done = '0;
                e_done[m_owner] = 1'b1;
                e_rsp  = (m_tout != 0) ? 16'h0000 : spi_rx_data;
                e_to   = (m_tout != 0);
                e_gnt  = '0;
                m_busy = 0;
            end else if (m_t >= 2) begin
                waited = m_t - 2;
                if (m_low == 0 && spi_cs == 1'b0) m_low = 1;
                else if (m_low != 0 && spi_cs == 1'b1) m_fin = 1;
                else if (waited == TO - 1) begin
                    m_fin  = 1;
                    m_tout = 1;
                end
            end
        end else if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (m_busy == 0 && req[c]) begin
                    m_busy  = 1;
                    m_owner = c;
                end
            end
            m_last = m_owner;
            m_t = 0; m_fin = 0; m_low = 0; m_tout = 0;
            e_gnt = '0;
            e_gnt[m_owner] = 1'b1;
            e_tx = req_data[m_owner*W +: W];
        end
        e_start = (m_busy != 0) && (m_t == 0);
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_clear();
            else m_step();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        chk("cyc_gnt",   32'(gnt),         32'(e_gnt));
        chk("cyc_done",  32'(done),        32'(e_done));
        chk("cyc_rsp",   32'(rsp_data),    32'(e_rsp));
        chk("cyc_to",    32'(timeout_err), 32'(e_to));
        chk("cyc_start", 32'(spi_start),   32'(e_start));
        chk("cyc_tx",    32'(spi_tx_data), 32'(e_tx));
    end

    // ---------------- Stimulus helpers ----------------
    logic         wd_ok;
    int           wd_starts, wd_start_cyc, wd_done_cyc, wd_gidx;
    logic [N-1:0] wd_done;
    logic [W-1:0] wd_rsp, wd_tx;
    logic         wd_to;

    // Waits (bounded) for a done pulse, recording the start pulse seen on the way.
    task automatic wait_done(input string name, input int max_cyc);
        wd_ok = 1'b0; wd_starts = 0; wd_gidx = -1; wd_start_cyc = 0;
        wd_done = '0; wd_rsp = '0; wd_tx = '0; wd_to = 1'b0; wd_done_cyc = 0;
        for (int c = 0; c < max_cyc && !wd_ok; c++) begin
            @(negedge clk);
            if (spi_start) begin
                wd_starts++;
                if (wd_starts == 1) begin
                    wd_gidx      = oh2i(gnt);
                    wd_tx        = spi_tx_data;
                    wd_start_cyc = cyc;
                end
            end
            if (done != '0) begin
                wd_ok       = 1'b1;
                wd_done     = done;
                wd_rsp      = rsp_data;
                wd_to       = timeout_err;
                wd_done_cyc = cyc;
            end
        end
        chk({name, "_done_seen"}, 32'(wd_ok), 32'd1);
    endtask

    task automatic wait_cs_low(input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (!spi_cs) seen = 1'b1;
        end
        chk({name, "_cs_low_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- Directed scenarios ----------------
    int exp_order [5];
    int prev_start;
    int extra_done;
    logic idle_seen;

    initial begin
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2;
        exp_order[3] = 3; exp_order[4] = 0;
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        m_hang   = 1'b0;
        m_rx     = 16'h5A5A;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt",   32'(gnt),         32'd0);
        chk("rst_start", 32'(spi_start),   32'd0);
        chk("rst_tx",    32'(spi_tx_data), 32'd0);
        chk("rst_done",  32'(done),        32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single request.
        req_data[15:0] = 16'hA5A5;
        req = 4'b0001;
        wait_done("single", 200);
        req = 4'b0000;
        chk("single_tx",     32'(wd_tx),     32'h0000A5A5);
        chk("single_starts", 32'(wd_starts), 32'd1);
        chk("single_done",   32'(wd_done),   32'b0001);
        chk("single_rsp",    32'(wd_rsp),    32'h00005A5A);
        chk("single_to",     32'(wd_to),     32'd0);
        @(negedge clk);
        chk("single_gnt_clr", 32'(gnt), 32'd0);

        // Round robin with all four requesters held.
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'hC000 + 16'(i);
        req = 4'b1111;
        prev_start = -100;
        for (int k = 0; k < 5; k++) begin
            wait_done("rr", 200);
            chk("rr_grant_idx", 32'(wd_gidx), 32'(exp_order[k]));
            chk("rr_tx", 32'(wd_tx), 32'(16'hC000 + 16'(exp_order[k])));
            chk("rr_gap_ge2", 32'((wd_start_cyc - prev_start) >= 2), 32'd1);
            prev_start = wd_start_cyc;
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Contention right after reset.
        do_reset();
        req = 4'b1010;
        wait_done("cont1", 200);
        req = 4'b1000;
        chk("cont_first", 32'(wd_gidx), 32'd1);
        wait_done("cont2", 200);
        req = 4'b0000;
        chk("cont_second", 32'(wd_gidx), 32'd3);

        // Timeout: master never answers.
        m_hang = 1'b1;
        req = 4'b0001;
        wait_done("tmo", 300);
        req = 4'b0000;
        m_hang = 1'b0;
        chk("tmo_done",    32'(wd_done), 32'b0001);
        chk("tmo_err",     32'(wd_to),   32'd1);
        chk("tmo_rsp",     32'(wd_rsp),  32'd0);
        // START cycle + TO wait cycles + DONE cycle
        chk("tmo_latency", 32'(wd_done_cyc - wd_start_cyc), 32'(TO + 2));
        m_rx = 16'h3C3C;
        req = 4'b0010;
        wait_done("after_tmo", 200);
        req = 4'b0000;
        chk("after_tmo_done", 32'(wd_done), 32'b0010);
        chk("after_tmo_rsp",  32'(wd_rsp),  32'h00003C3C);
        chk("after_tmo_err",  32'(wd_to),   32'd0);

        // Reset while waiting for cs to rise.
        req = 4'b0001;
        wait_cs_low("midrst");
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_gnt",   32'(gnt),         32'd0);
        chk("midrst_done",  32'(done),        32'd0);
        chk("midrst_rsp",   32'(rsp_data),    32'd0);
        chk("midrst_to",    32'(timeout_err), 32'd0);
        chk("midrst_start", 32'(spi_start),   32'd0);
        chk("midrst_tx",    32'(spi_tx_data), 32'd0);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle_seen = 1'b0;
        for (int c = 0; c < 100 && !idle_seen; c++) begin
            @(negedge clk);
            if (mst == 0) idle_seen = 1'b1;
        end
        chk("midrst_master_idle", 32'(idle_seen), 32'd1);
        req_data[2*W +: W] = 16'h1234;
        req = 4'b0100;
        wait_done("midrst_next", 200);
        req = 4'b0000;
        chk("midrst_next_idx",  32'(wd_gidx), 32'd2);
        chk("midrst_next_tx",   32'(wd_tx),   32'h00001234);
        chk("midrst_next_done", 32'(wd_done), 32'b0100);
        chk("midrst_next_rsp",  32'(wd_rsp),  32'h00003C3C);

        // Request withdrawn while cs is low.
        m_rx = 16'h0F0F;
        req_data[15:0] = 16'h7E81;
        req = 4'b0001;
        wait_cs_low("wdraw");
        req = 4'b0000;
        wait_done("wdraw", 200);
        chk("wdraw_done", 32'(wd_done), 32'b0001);
        chk("wdraw_rsp",  32'(wd_rsp),  32'h00000F0F);
        extra_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done != '0) extra_done++;
        end
        chk("wdraw_single_pulse", 32'(extra_done), 32'd0);
        chk("wdraw_gnt_clr",      32'(gnt),        32'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares the single 16-bit SPI master between `N_REQ` on-chip requesters, such as ADC readout and gate-driver configuration. Round-robin arbitration selects one pending request. The block launches it on the master, tracks `cs` to detect completion, returns the received word to the granted requester, and recovers from a stalled master via a timeout. It sits directly between the requester logic and the SPI master's `start_transfer`/`data_to_tx`/`data_to_rx`/`cs` ports.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 16: SPI word width; must match the master.
- `TIMEOUT_CYC`, 1024: maximum clk cycles from start pulse to end of transfer.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `req`  in  N_REQ  per-requester request level; held until its `done` bit.
- `req_data`  in  N_REQ*DATA_W  word to send; slice i belongs to requester i; stable while `req[i]`=1.
- `gnt`  out  N_REQ  one-hot grant, held for the whole transaction.
- `done`  out  N_REQ  one-cycle completion pulse to the granted requester.
- `rsp_data`  out  DATA_W  received word; valid in the `done` cycle; held until the next `done`.
- `timeout_err`  out  1  one-cycle pulse coincident with `done` when the transfer timed out.
- `spi_start`  out  1  to master `start_transfer`; one-cycle pulse.
- `spi_tx_data`  out  DATA_W  to master `data_to_tx`; registered, held through the transaction.
- `spi_rx_data`  in  DATA_W  from master `data_to_rx`.
- `spi_cs`  in  1  from master `cs`; active-low; same clock domain, no synchronizer.

## Operation
- States: IDLE, START, WAIT_LOW, WAIT_HIGH, DONE.
- **IDLE**
  - If any `req` bit is set, pick the winner by round robin.
  - Search starts at `last+1` (mod N_REQ).
  - Latch `gnt`, then `spi_tx_data` = the winner's slice, then `last` = winner.
  - Go to START.
- **START:** `spi_start`=1 for exactly this cycle. Go to WAIT_LOW.
- **WAIT_LOW:** wait for `spi_cs`=0, then go to WAIT_HIGH.
- **WAIT_HIGH:** wait for `spi_cs`=1, then go to DONE.
- **DONE**
  - Capture `spi_rx_data` into `rsp_data`.
  - Pulse `done[winner]`.
  - Clear `gnt`. Go to IDLE.
- **Timeout:** a counter clears in START and increments in WAIT_LOW/WAIT_HIGH.
  - When it reaches `TIMEOUT_CYC`-1, go to DONE with `timeout_err`=1 and `rsp_data`=0.
- **Request dropped mid-transaction:** ignored. The transfer completes and `done` still pulses.
- **Non-granted requests during a transaction:** wait. No preemption.
- **Reset** (any state, asynchronous): state=IDLE.
  - Clears: `gnt`, `done`, `timeout_err`, `spi_start`, `spi_tx_data`, `rsp_data`, counter.
  - `last`=N_REQ-1, so requester 0 has first priority.
  - A transfer in flight on the master is abandoned; the arbiter does not wait for `cs`.

## Timing
- `req` seen in IDLE at edge k:
  - edge k+1: `gnt` and `spi_tx_data` valid; `spi_start`=1 (START state).
  - edge k+2: `spi_start`=0.
- `done`/`rsp_data` valid one cycle after the first cycle `spi_cs`=1 is sampled in WAIT_HIGH.
- After DONE, one IDLE cycle always elapses before the next START. Minimum 2-cycle gap between grants.
- All outputs are registered; no combinational path from `req` or `spi_cs` to any output.

## Structure
- Shared package `spi_pkg`:
  - state enum/localparams for the 5 states;
  - `SPI_DATA_W`=16;
  - default `TIMEOUT_CYC`.
- One sub-module `rr_arbiter`:
  - inputs: `req` and `last`;
  - outputs: one-hot winner and its index;
  - purely combinational, parameterized by N_REQ.
- FSM, counter and datapath registers live in `spi_arbiter`.

## Test plan
- **Single request:** `req`=0001, `req_data[15:0]`=16'hA5A5; master model drops `cs` 3 cycles after start, 32 cycles low, MISO pattern gives 16'h5A5A.
  - `spi_tx_data`=A5A5 and one `spi_start` pulse.
  - `done`=0001 with `rsp_data`=5A5A; `gnt` clears.
- **Round robin:** `req`=1111 held continuously.
  - Grant order 0,1,2,3,0.
  - Each `spi_tx_data` matches the granted slice.
  - ≥2-cycle gap between consecutive `spi_start` pulses.
- **Contention after reset:** `req`=1010 after reset → requester 1 first, then 3.
- **Timeout:** master never lowers `cs`; `TIMEOUT_CYC`=64.
  - `done`+`timeout_err` pulse after 64 cycles with `rsp_data`=0.
  - Next request is served normally.
- **Reset mid-transfer:** assert `reset`=0 in WAIT_HIGH.
  - All outputs 0 immediately.
  - After release, `req`=0100 is granted to requester 2 cleanly.
- **Request withdrawn:** `req[0]` drops in WAIT_LOW → transfer completes and `done[0]` still pulses once.
